// File: rtl/elevator_ctrl.sv
// -----------------------------------------------------------------------------
// elevator_ctrl
// Car-motion scheduler. Reads the latched request vectors from the hall/cab
// request register, moves the car one floor at a time, stops at floors whose
// requests match the travel direction, holds the door open, and pulses the
// matching clear lines back to the request register.
//
// Parameters:
//   BUTTONS_WIDTH  number of floors (2..15; 4'hF is the "none blocked" code)
//   MOVE_CYCLES    clock cycles spent travelling one floor (>= 1)
//   DOOR_CYCLES    clock cycles the door stays open (>= 1)
//
// Ports:
//   clk                         system clock, rising edge
//   reset                       synchronous, active-low reset
//   active_in_levels            pending cab requests, one per floor
//   active_out_up_levels        pending hall-up requests (no up button on top floor)
//   active_out_down_levels      pending hall-down requests (no down button on floor 0)
//   inactivate_in_levels        one-cycle clear pulse, cab
//   inactivate_out_up_levels    one-cycle clear pulse, hall-up
//   inactivate_out_down_levels  one-cycle clear pulse, hall-down
//   buttons_blocked             floor whose buttons are ignored, 4'hF = none
//   current_floor               car position
//   direction                   00 idle, 01 up, 10 down
//   door_open                   high while the door is open
// -----------------------------------------------------------------------------
module elevator_ctrl #(
   parameter int BUTTONS_WIDTH = 8,
   parameter int MOVE_CYCLES   = 4,
   parameter int DOOR_CYCLES   = 6
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [BUTTONS_WIDTH-1:0] active_in_levels,
   input  logic [BUTTONS_WIDTH-2:0] active_out_up_levels,
   input  logic [BUTTONS_WIDTH-1:1] active_out_down_levels,
   output logic [BUTTONS_WIDTH-1:0] inactivate_in_levels,
   output logic [BUTTONS_WIDTH-2:0] inactivate_out_up_levels,
   output logic [BUTTONS_WIDTH-1:1] inactivate_out_down_levels,
   output logic [3:0]               buttons_blocked,
   output logic [3:0]               current_floor,
   output logic [1:0]               direction,
   output logic                     door_open
);

   localparam int W   = BUTTONS_WIDTH;
   localparam int MCW = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
   localparam int DCW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

   localparam logic [MCW-1:0] MOVE_LAST = MCW'(MOVE_CYCLES - 1);
   localparam logic [DCW-1:0] DOOR_LAST = DCW'(DOOR_CYCLES - 1);

   localparam logic [1:0] DIR_IDLE = 2'b00;
   localparam logic [1:0] DIR_UP   = 2'b01;
   localparam logic [1:0] DIR_DOWN = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MOVE,
      S_CHECK,
      S_DOOR
   } state_t;

   // State registers
   state_t         state_reg, state_next;
   logic [3:0]     floor_reg, floor_next;
   logic [1:0]     dir_reg, dir_next;
   logic [MCW-1:0] move_cnt_reg, move_cnt_next;
   logic [DCW-1:0] door_cnt_reg, door_cnt_next;
   logic [W-1:0]   clr_in_reg, clr_in_next;
   logic [W-2:0]   clr_up_reg, clr_up_next;
   logic [W-1:1]   clr_down_reg, clr_down_next;

   // Per-floor request view, padded so every floor has all three bits
   logic [W-1:0] up_vec;
   logic [W-1:0] down_vec;
   logic [W-1:0] req_vec;
   logic [W-1:0] here_vec;
   logic [W-1:0] above_vec;
   logic [W-1:0] below_vec;

   genvar gi;
   generate
      for (gi = 0; gi < W; gi++) begin : g_floor
         if (gi <= W - 2) begin : g_up
            assign up_vec[gi] = active_out_up_levels[gi];
         end else begin : g_no_up
            assign up_vec[gi] = 1'b0;
         end

         if (gi >= 1) begin : g_down
            assign down_vec[gi] = active_out_down_levels[gi];
         end else begin : g_no_down
            assign down_vec[gi] = 1'b0;
         end

         assign req_vec[gi]   = active_in_levels[gi] | up_vec[gi] | down_vec[gi];
         assign here_vec[gi]  = (4'(gi) == floor_reg);
         assign above_vec[gi] = (4'(gi) >  floor_reg);
         assign below_vec[gi] = (4'(gi) <  floor_reg);
      end
   endgenerate

   // Floor-relative summaries; above is structurally 0 at the top floor and
   // below is 0 at floor 0 because the masks are empty there.
   logic in_here, up_here, down_here, req_here;
   logic above, below, further;

   assign in_here   = |(active_in_levels & here_vec);
   assign up_here   = |(up_vec & here_vec);
   assign down_here = |(down_vec & here_vec);
   assign req_here  = |(req_vec & here_vec);
   assign above     = |(req_vec & above_vec);
   assign below     = |(req_vec & below_vec);

   always_comb begin
      further = 1'b0;
      if (dir_reg == DIR_UP) begin
         further = above;
      end else if (dir_reg == DIR_DOWN) begin
         further = below;
      end
   end

   // Next-state and clear-pulse selection
   logic sel_in, sel_up, sel_down, stop_here;

   always_comb begin
      state_next    = state_reg;
      floor_next    = floor_reg;
      dir_next      = dir_reg;
      move_cnt_next = move_cnt_reg;
      door_cnt_next = door_cnt_reg;
      sel_in        = 1'b0;
      sel_up        = 1'b0;
      sel_down      = 1'b0;
      stop_here     = in_here
                    | (up_here & (dir_reg == DIR_UP))
                    | (down_here & (dir_reg == DIR_DOWN))
                    | (!further & req_here);

      case (state_reg)
         S_IDLE: begin
            if (req_here) begin
               // Serviced in place: everything at this floor is cleared.
               state_next    = S_DOOR;
               door_cnt_next = '0;
               dir_next      = DIR_IDLE;
               sel_in        = 1'b1;
               sel_up        = 1'b1;
               sel_down      = 1'b1;
            end else if (above) begin
               dir_next      = DIR_UP;
               state_next    = S_MOVE;
               move_cnt_next = '0;
            end else if (below) begin
               dir_next      = DIR_DOWN;
               state_next    = S_MOVE;
               move_cnt_next = '0;
            end
         end

         S_MOVE: begin
            if (move_cnt_reg == MOVE_LAST) begin
               floor_next    = (dir_reg == DIR_DOWN) ? floor_reg - 4'd1 : floor_reg + 4'd1;
               move_cnt_next = '0;
               state_next    = S_CHECK;
            end else begin
               move_cnt_next = move_cnt_reg + MCW'(1);
            end
         end

         S_CHECK: begin
            if (stop_here) begin
               state_next    = S_DOOR;
               door_cnt_next = '0;
               sel_in        = 1'b1;
               sel_up        = (dir_reg == DIR_UP);
               sel_down      = (dir_reg == DIR_DOWN);
               if (!further) begin
                  // End of travel or reversal: the opposite hall call is
                  // answered too and the car becomes directionless.
                  sel_up   = 1'b1;
                  sel_down = 1'b1;
                  dir_next = DIR_IDLE;
               end
            end else if (further) begin
               state_next    = S_MOVE;
               move_cnt_next = '0;
            end else begin
               state_next = S_IDLE;
               dir_next   = DIR_IDLE;
            end
         end

         S_DOOR: begin
            if (door_cnt_reg == DOOR_LAST) begin
               door_cnt_next = '0;
               if (((dir_reg == DIR_UP) && above) || ((dir_reg == DIR_DOWN) && below)) begin
                  state_next    = S_MOVE;
                  move_cnt_next = '0;
               end else begin
                  state_next = S_IDLE;
                  dir_next   = DIR_IDLE;
               end
            end else begin
               door_cnt_next = door_cnt_reg + DCW'(1);
            end
         end

         default: begin
            state_next = S_IDLE;
            dir_next   = DIR_IDLE;
         end
      endcase

      // Only requests that are actually pending receive a clear pulse, and
      // only at the current floor, so at most one floor pulses per cycle.
      clr_in_next   = here_vec & active_in_levels & {W{sel_in}};
      clr_up_next   = here_vec[W-2:0] & active_out_up_levels & {(W-1){sel_up}};
      clr_down_next = here_vec[W-1:1] & active_out_down_levels & {(W-1){sel_down}};
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg    <= S_IDLE;
         floor_reg    <= '0;
         dir_reg      <= DIR_IDLE;
         move_cnt_reg <= '0;
         door_cnt_reg <= '0;
         clr_in_reg   <= '0;
         clr_up_reg   <= '0;
         clr_down_reg <= '0;
      end else begin
         state_reg    <= state_next;
         floor_reg    <= floor_next;
         dir_reg      <= dir_next;
         move_cnt_reg <= move_cnt_next;
         door_cnt_reg <= door_cnt_next;
         clr_in_reg   <= clr_in_next;
         clr_up_reg   <= clr_up_next;
         clr_down_reg <= clr_down_next;
      end
   end

   assign inactivate_in_levels       = clr_in_reg;
   assign inactivate_out_up_levels   = clr_up_reg;
   assign inactivate_out_down_levels = clr_down_reg;
   assign current_floor              = floor_reg;
   assign direction                  = dir_reg;
   assign door_open                  = (state_reg == S_DOOR);
   assign buttons_blocked            = (state_reg == S_DOOR) ? floor_reg : 4'hF;

endmodule

// File: tb/tb_elevator_ctrl.sv
// -----------------------------------------------------------------------------
// tb_elevator_ctrl
// Directed and randomized request sets driven through an emulated request
// register. A stop-level reference model predicts, for each stop, the floor,
// arrival cycle, cleared bits and resulting direction from the scheduling
// rules (nearest qualifying floor in the travel direction).
// -----------------------------------------------------------------------------
module tb_elevator_ctrl;
   localparam int W = 8;
   localparam int M = 4;
   localparam int D = 6;
   localparam bit [W-1:0] UP_MASK = {1'b0, {(W-1){1'b1}}};
   localparam bit [W-1:0] DN_MASK = {{(W-1){1'b1}}, 1'b0};

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic [W-1:0] drv_in = '0;
   logic [W-2:0] drv_up = '0;
   logic [W-1:1] drv_dn = '0;
   logic [W-1:0] inact_in;
   logic [W-2:0] inact_up;
   logic [W-1:1] inact_dn;
   logic [3:0]   buttons_blocked;
   logic [3:0]   current_floor;
   logic [1:0]   direction;
   logic         door_open;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // Reference model state: pending requests, car floor, car direction
   bit [W-1:0] m_in, m_up, m_dn;
   int m_floor = 0;
   int m_dir = 0;

   elevator_ctrl #(
      .BUTTONS_WIDTH(W),
      .MOVE_CYCLES(M),
      .DOOR_CYCLES(D)
   ) dut (
      .clk(clk),
      .reset(reset),
      .active_in_levels(drv_in),
      .active_out_up_levels(drv_up),
      .active_out_down_levels(drv_dn),
      .inactivate_in_levels(inact_in),
      .inactivate_out_up_levels(inact_up),
      .inactivate_out_down_levels(inact_dn),
      .buttons_blocked(buttons_blocked),
      .current_floor(current_floor),
      .direction(direction),
      .door_open(door_open)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One cycle: sample at the falling edge, check invariants, then behave
   // like the request register and drop any bit that was pulsed.
   task automatic step();
      logic [W-1:0] pulsed;
      @(negedge clk);
      pulsed = inact_in | {1'b0, inact_up} | {inact_dn, 1'b0};
      chk("floor_in_range", 32'(current_floor <= 4'(W - 1)), 1);
      chk("one_floor_pulsed", 32'($countones(pulsed) <= 1), 1);
      drv_in = drv_in & ~inact_in;
      drv_up = drv_up & ~inact_up;
      drv_dn = drv_dn & ~inact_dn;
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_floor"}, current_floor, 0);
      chk({tag, "_dir"}, direction, 0);
      chk({tag, "_door"}, door_open, 0);
      chk({tag, "_blocked"}, buttons_blocked, 4'hF);
      chk({tag, "_pulses"}, {inact_in, inact_up, inact_dn}, 0);
   endtask

   task automatic resync();
      reset  = 1'b0;
      drv_in = '0;
      drv_up = '0;
      drv_dn = '0;
      step();
      step();
      reset = 1'b1;
      m_in = '0; m_up = '0; m_dn = '0;
      m_floor = 0;
      m_dir = 0;
      step();
   endtask

   function automatic bit req_at(int k);
      return m_in[k] | m_up[k] | m_dn[k];
   endfunction

   function automatic bit any_req(int lo, int hi);
      bit r = 1'b0;
      for (int k = lo; k <= hi; k++) begin
         if (k >= 0 && k < W) r |= req_at(k);
      end
      return r;
   endfunction

   // Next stop from the model's floor/direction and pending set.
   task automatic model_next(output int k, output int trav, output int nd,
                             output bit [W-1:0] ci, output bit [W-1:0] cu,
                             output bit [W-1:0] cd);
      int d;
      bit beyond;
      d = m_dir;
      ci = '0; cu = '0; cd = '0;
      k = m_floor;
      trav = 0;
      nd = 0;
      if (d == 0 && req_at(m_floor)) begin
         ci[k] = 1'b1; cu[k] = 1'b1; cd[k] = 1'b1;
      end else begin
         if (d == 0) d = any_req(m_floor + 1, W - 1) ? 1 : 2;
         trav = d;
         beyond = 1'b1;
         for (int s = 0; s < W; s++) begin
            k = (d == 1) ? k + 1 : k - 1;
            if (k < 0 || k >= W) break;
            beyond = (d == 1) ? any_req(k + 1, W - 1) : any_req(0, k - 1);
            if (m_in[k] || ((d == 1) ? m_up[k] : m_dn[k]) || (!beyond && req_at(k))) break;
         end
         ci[k] = 1'b1;
         if (d == 1) cu[k] = 1'b1; else cd[k] = 1'b1;
         if (!beyond) begin
            cu[k] = 1'b1;
            cd[k] = 1'b1;
            nd = 0;
         end else begin
            nd = d;
         end
      end
      // Only pending requests are pulsed
      ci = ci & m_in;
      cu = cu & m_up;
      cd = cd & m_dn;
   endtask

   // Present a request set at idle and follow the car until all are served.
   task automatic run_requests(input string name, input bit [W-1:0] ri,
                               input bit [W-1:0] ru_in, input bit [W-1:0] rd_in);
      int k, trav, nd, n, s, exp_door, j, sgn, dc;
      bit [W-1:0] ci, cu, cd, ru, rd;
      bit seen;
      ru = ru_in & UP_MASK;
      rd = rd_in & DN_MASK;
      drv_in = ri;
      drv_up = ru[W-2:0];
      drv_dn = rd[W-1:1];
      m_in = ri; m_up = ru; m_dn = rd;
      $display("scenario %s: from floor %0d in=%h up=%h dn=%h", name, m_floor, ri, ru, rd);
      s = cyc + 1;
      while ((m_in | m_up | m_dn) != '0) begin
         model_next(k, trav, nd, ci, cu, cd);
         n   = (k > m_floor) ? k - m_floor : m_floor - k;
         sgn = (k > m_floor) ? 1 : -1;
         exp_door = s + n * (M + 1);
         j = 0;
         seen = 1'b0;
         for (int t = 0; t < W * (M + 1) + 10; t++) begin
            step();
            if (door_open) begin
               seen = 1'b1;
               break;
            end
            if (cyc == s) chk("travel_dir", direction, trav);
            if (current_floor != 4'(m_floor + j * sgn)) begin
               j++;
               chk("floor_step", current_floor, m_floor + j * sgn);
               chk("step_time", cyc, s + j * (M + 1) - 1);
            end
         end
         if (!seen) begin
            chk("door_timeout", 0, 1);
            resync();
            return;
         end
         chk("door_time", cyc, exp_door);
         chk("stop_floor", current_floor, k);
         chk("pulse_in", inact_in, ci);
         chk("pulse_up", inact_up, cu[W-2:0]);
         chk("pulse_dn", inact_dn, cd[W-1:1]);
         chk("blocked", buttons_blocked, k);
         chk("door_dir", direction, nd);
         $display("  stop floor=%0d cycle=%0d dir=%0d clr_in=%h clr_up=%h clr_dn=%h",
                  k, cyc, nd, ci, cu, cd);
         m_in = m_in & ~ci;
         m_up = m_up & ~cu;
         m_dn = m_dn & ~cd;
         m_floor = k;
         m_dir = nd;
         dc = 1;
         for (int t = 0; t < D + 5; t++) begin
            step();
            if (!door_open) break;
            dc++;
            if (dc == 2) chk("pulse_len", {inact_in, inact_up, inact_dn}, 0);
            chk("blocked_hold", buttons_blocked, k);
         end
         chk("door_len", dc, D);
         if (door_open) begin
            resync();
            return;
         end
         chk("blocked_clear", buttons_blocked, 4'hF);
         chk("dir_after_door", direction, m_dir);
         s = (m_dir != 0) ? cyc : cyc + 1;
      end
      repeat (3) step();
      chk("idle_door", door_open, 0);
      chk("idle_dir", direction, 0);
      chk("idle_floor", current_floor, m_floor);
   endtask

   initial begin
      bit [W-1:0] ri, ru, rd;
      int s;

      // Reset state
      reset = 1'b0;
      repeat (3) step();
      check_reset_state("reset");
      reset = 1'b1;
      step();
      check_reset_state("after_release");

      // Directed cases
      run_requests("cab0_at_floor0", 8'h01, 8'h00, 8'h00);
      run_requests("cab3", 8'h08, 8'h00, 8'h00);
      run_requests("home", 8'h01, 8'h00, 8'h00);
      run_requests("cab5_down2", 8'h20, 8'h00, 8'h04);
      run_requests("home", 8'h01, 8'h00, 8'h00);
      run_requests("up2_down2_cab6", 8'h40, 8'h04, 8'h04);
      run_requests("home", 8'h01, 8'h00, 8'h00);
      run_requests("down7_top", 8'h00, 8'h00, 8'h80);

      // Randomized request sets
      for (int it = 0; it < 25; it++) begin
         ri = '0; ru = '0; rd = '0;
         for (int k = 0; k < W; k++) begin
            if ($urandom_range(0, 4) == 0) ri[k] = 1'b1;
            if ($urandom_range(0, 5) == 0) ru[k] = 1'b1;
            if ($urandom_range(0, 5) == 0) rd[k] = 1'b1;
         end
         ru = ru & UP_MASK;
         rd = rd & DN_MASK;
         if ((ri | ru | rd) == '0) ri[$urandom_range(0, W - 1)] = 1'b1;
         run_requests("random", ri, ru, rd);
      end

      // Reset in the middle of travel at floor 4, move counter at 2
      reset = 1'b0;
      step();
      check_reset_state("pre_travel_reset");
      reset = 1'b1;
      m_in = '0; m_up = '0; m_dn = '0;
      m_floor = 0;
      m_dir = 0;
      step();
      drv_in = 8'h80;
      s = cyc + 1;
      $display("scenario reset_mid_move: cab7 from floor 0, reset at cycle %0d", s + 4 * (M + 1) + 2);
      for (int t = 0; t < 200; t++) begin
         step();
         if (cyc >= s + 4 * (M + 1) + 2) break;
      end
      chk("mid_move_floor", current_floor, 4);
      chk("mid_move_dir", direction, 1);
      chk("mid_move_door", door_open, 0);
      reset = 1'b0;
      step();
      check_reset_state("mid_move_reset");
      drv_in = '0;
      drv_up = '0;
      drv_dn = '0;
      reset = 1'b1;
      repeat (3) step();
      check_reset_state("post_reset_idle");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/elevator_ctrl.md
Name: elevator_ctrl

Overview:
- Car-motion scheduler; the consumer end of the hall/cab request register in the elevator design.
- Reads latched request vectors (cab, hall-up, hall-down), moves the car floor by floor and stops at floors with matching requests.
- On each stop: opens the door, pulses the matching inactivate_* lines back to the request register, and reports the blocked floor via buttons_blocked.

Parameters:
- BUTTONS_WIDTH, 8, number of floors; legal range 2..15 (4'hF is reserved as the "none blocked" code).
- MOVE_CYCLES, 4, clock cycles to travel one floor; must be ≥1.
- DOOR_CYCLES, 6, clock cycles the door stays open; must be ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- active_in_levels  in  BUTTONS_WIDTH [W-1:0]  pending cab requests.
- active_out_up_levels  in  [W-2:0]  pending hall-up requests.
- active_out_down_levels  in  [W-1:1]  pending hall-down requests.
- inactivate_in_levels  out  [W-1:0]  one-cycle clear pulse, cab.
- inactivate_out_up_levels  out  [W-2:0]  one-cycle clear pulse, hall-up.
- inactivate_out_down_levels  out  [W-1:1]  one-cycle clear pulse, hall-down.
- buttons_blocked  out  4  index of the floor whose buttons are ignored; 4'hF = none.
- current_floor  out  4  car position.
- direction  out  2  00 idle, 01 up, 10 down.
- door_open  out  1  high while in DOOR.

Behaviour:
Reset (reset low at a clock edge, including mid-MOVE or mid-DOOR):
- state IDLE, current_floor 0, direction 00, door_open 0, buttons_blocked 4'hF.
- All inactivate pulses 0; move and door counters 0.

Derived signals, combinational on registered current_floor f:
- req[k] = in[k] | up[k] | down[k], with nonexistent bits treated as 0.
- above = OR of req[k] for k>f; below = OR of req[k] for k<f.

States: IDLE, MOVE, CHECK, DOOR.

IDLE:
- req[f] → DOOR with service at f. Direction stays 00; clear in[f], up[f] and down[f].
- else above → direction 01, MOVE.
- else below → direction 10, MOVE.
- else stay in IDLE.
- Above wins over below on a tie.

MOVE:
- Counter runs 0..MOVE_CYCLES-1.
- On the edge where the counter reaches terminal count: current_floor ±1 per direction, counter resets to 0, state → CHECK.
- Total cost per floor is MOVE_CYCLES+1 cycles, including CHECK.

CHECK: with further = above for up, below for down.
- Stop if in[f], or up[f] while going up, or down[f] while going down, or (!further & req[f]).
- Stop → DOOR.
- else further → MOVE.
- else → IDLE with direction 00.

DOOR entry (the edge entering DOOR):
- In the first DOOR cycle only, pulse inactivate_in[f].
- Also pulse the hall bit matching direction.
- If !further (reversal or end of travel), also pulse the opposite hall bit and set direction 00.

DOOR hold:
- door_open=1 and buttons_blocked=f for DOOR_CYCLES cycles.
- Request inputs at f are not re-evaluated during DOOR.

DOOR exit:
- direction 01 & above → MOVE.
- direction 10 & below → MOVE.
- else → IDLE with direction 00; IDLE re-evaluates in the next cycle.
- On exit: buttons_blocked 4'hF, door_open 0.

Boundaries:
- The car never moves below 0 or above W-1; above is structurally 0 at the top floor and below is 0 at floor 0.
- Requests may appear or disappear in any cycle and are sampled only in IDLE, CHECK and at DOOR exit.
- A request arriving for the current floor while in MOVE is handled at the next CHECK for the floor it applies to, never by backing up.
- At most one floor's inactivate bits are high in any cycle.

Test Plan:
1. MOVE_CYCLES=4, DOOR_CYCLES=6, reset released at floor 0, in=8'h08 held until cleared.
   - Required: direction=01 one cycle after request.
   - current_floor steps 1, 2, 3, one step every 5 cycles.
   - At floor 3: inactivate_in_levels=8'h08 for exactly 1 cycle, buttons_blocked=3 and door_open=1 for 6 cycles, then IDLE with buttons_blocked=4'hF and direction=00.
2. Idle at floor 0, in[0]=1 → DOOR on the next edge.
   - Required: inactivate_in[0] pulse, current_floor stays 0, door open 6 cycles.
3. Floor 0 with in[5] and down[2] held:
   - Car passes floor 2 without stopping, stops at 5 and pulses in[5].
   - Car reverses, stops at 2 with inactivate_out_down[2] pulse and direction 00, then ends in IDLE.
4. Floor 0 with up[2], down[2], in[6] held:
   - Stop at 2 pulses in[2]=0 and up[2]=1 only; down[2] stays pending.
   - Car continues to 6, then returns to 2 to service down[2].
5. Floor 0 with down[7] only:
   - Car travels to 7 and pulses down[7].
   - current_floor never exceeds 7; direction=00 after the stop.
6. reset driven low during MOVE at current_floor=4, counter=2 → at the next edge: current_floor=0, IDLE, door_open=0, buttons_blocked=4'hF, no inactivate pulse.
